// File: rtl/neuron_pkg.sv
// Shared Q4.4 constants and the MAC sequencer state encoding for the neuron datapath.
package neuron_pkg;

   localparam int DATA_W = 8;
   localparam int FRAC_W = 4;

   localparam logic signed [DATA_W-1:0] Q_MAX = 8'sh7F;
   localparam logic signed [DATA_W-1:0] Q_MIN = 8'sh80;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      FINAL,
      OUT
   } state_t;

endpackage

// File: rtl/neuron_sat.sv
// Narrows a signed ACC_W-bit Q(.FRAC_W) sum to an 8-bit signed Q4.4 value:
// arithmetic shift (optionally rounded half-up), then saturation to [-128, 127].
module neuron_sat #(
   parameter int ACC_W    = 20,
   parameter int FRAC_W   = 4,
   parameter bit ROUND_EN = 1'b0
) (
   input  logic [ACC_W-1:0] sum,
   output logic [7:0]       z
);
   import neuron_pkg::*;

   localparam logic signed [ACC_W:0] HALF   = (ACC_W+1)'(1) <<< (FRAC_W - 1);
   localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(Q_MAX);
   localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(Q_MIN);

   // One guard bit keeps the rounding add from wrapping at the top of the range.
   function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W:0] t;
      t = (ACC_W+1)'(v);
      if (ROUND_EN) begin
         t = t + HALF;
      end
      return t >>> FRAC_W;
   endfunction

   function automatic logic [7:0] saturate(input logic signed [ACC_W:0] v);
      logic [7:0] r;
      if (v > SAT_HI) begin
         r = Q_MAX;
      end else if (v < SAT_LO) begin
         r = Q_MIN;
      end else begin
         r = v[7:0];
      end
      return r;
   endfunction

   logic signed [ACC_W-1:0] sum_s;

   assign sum_s = sum;
   assign z     = saturate(round_shift(sum_s));

endmodule

// File: rtl/neuron_mac_z.sv
// Sequential multiply-accumulate producing a neuron pre-activation z = sum(x*w) + b in Q4.4.
// Build option: define NEURON_MAC_ROUND_EN for round-half-up instead of truncation toward -inf.
module neuron_mac_z #(
   parameter int N_INPUTS = 4,
   parameter int FRAC_W   = 4,
   parameter int ACC_W    = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] bias,
   input  logic       x_valid,
   output logic       x_ready,
   input  logic [7:0] x_data,
   input  logic [7:0] w_data,
   output logic       z_valid,
   input  logic       z_ready,
   output logic [7:0] z_value,
   output logic       busy
);
   import neuron_pkg::*;

`ifdef NEURON_MAC_ROUND_EN
   localparam bit ROUND_EN = 1'b1;
`else
   localparam bit ROUND_EN = 1'b0;
`endif

   localparam int CNT_W = $clog2(N_INPUTS + 1);

   state_t                  state;
   state_t                  state_nxt;
   logic [CNT_W-1:0]        cnt;
   logic signed [ACC_W-1:0] acc;
   logic signed [7:0]       bias_q;
   logic [7:0]              z_q;

   logic signed [7:0]       x_s;
   logic signed [7:0]       w_s;
   logic signed [15:0]      prod_p0;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] bias_ext;
   logic signed [ACC_W-1:0] sum_fin;
   logic [7:0]              z_sat;
   logic                    beat;
   logic                    last_beat;

   // Q4.4 x Q4.4 gives a Q8.8 product; the accumulator stays in Q.8.
   assign x_s      = x_data;
   assign w_s      = w_data;
   assign prod_p0  = x_s * w_s;
   assign prod_ext = ACC_W'(prod_p0);

   // Bias is aligned to the accumulator's Q.8 scale before the final add.
   assign bias_ext = ACC_W'(bias_q);
   assign sum_fin  = acc + (bias_ext <<< FRAC_W);

   assign beat      = (state == ACCUM) && x_valid;
   assign last_beat = beat && (cnt == CNT_W'(N_INPUTS - 1));

   neuron_sat #(
      .ACC_W    (ACC_W),
      .FRAC_W   (FRAC_W),
      .ROUND_EN (ROUND_EN)
   ) u_sat (
      .sum (sum_fin),
      .z   (z_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      x_ready   = 1'b0;
      z_valid   = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            x_ready = 1'b1;
            if (last_beat) begin
               state_nxt = FINAL;
            end
         end
         FINAL: begin
            state_nxt = OUT;
         end
         OUT: begin
            z_valid = 1'b1;
            if (z_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         cnt    <= '0;
         bias_q <= '0;
         z_q    <= '0;
      end else begin
         if ((state == IDLE) && start) begin
            bias_q <= bias;
            acc    <= '0;
            cnt    <= '0;
         end else if (beat) begin
            acc <= acc + prod_ext;
            cnt <= cnt + CNT_W'(1);
         end
         // Result register: written once per evaluation, held through OUT.
         if (state == FINAL) begin
            z_q <= z_sat;
         end
      end
   end

   assign z_value = z_q;

endmodule

// File: tb/tb_neuron_mac_z.sv
// Directed self-checking bench for neuron_mac_z with an arithmetic reference model.
module tb_neuron_mac_z;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] bias;
   logic       x_valid;
   logic       x_ready;
   logic [7:0] x_data;
   logic [7:0] w_data;
   logic       z_valid;
   logic       z_ready;
   logic [7:0] z_value;
   logic       busy;

   int n_checks = 0;
   int n_errs   = 0;
   int exp_z    = 0;
   int got;

   logic signed [7:0] xv [N];
   logic signed [7:0] wv [N];

   always #5 clk = ~clk;

   neuron_mac_z #(
      .N_INPUTS (N),
      .FRAC_W   (4),
      .ACC_W    (20)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bias    (bias),
      .x_valid (x_valid),
      .x_ready (x_ready),
      .x_data  (x_data),
      .w_data  (w_data),
      .z_valid (z_valid),
      .z_ready (z_ready),
      .z_value (z_value),
      .busy    (busy)
   );

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errs++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // z = floor((sum(x*w) + 16*b [+ 8]) / 16), clamped to a signed byte.
   function automatic int model_z(input logic signed [7:0] b);
      int s;
      s = 0;
      for (int i = 0; i < N; i++) begin
         s += int'(xv[i]) * int'(wv[i]);
      end
      s += int'(b) * 16;
`ifdef NEURON_MAC_ROUND_EN
      s += 8;
`endif
      s = s >>> 4;
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
      return s & 'hFF;
   endfunction

   task automatic set_vec(input logic [7:0] xval, input logic [7:0] wval);
      for (int i = 0; i < N; i++) begin
         xv[i] = xval;
         wv[i] = wval;
      end
   endtask

   // Whenever a result is presented it must match the model.
   always @(negedge clk) begin
      if (rst === 1'b0 && z_valid === 1'b1) begin
         chk("z_value_vs_model", int'(z_value), exp_z);
      end
   end

   task automatic run_eval(input logic [7:0] b, input bit gaps, input int hold,
                           input string tag, output int result);
      exp_z   = model_z(b);
      z_ready = (hold == 0);
      start   = 1'b1;
      bias    = b;
      tick();
      start   = 1'b0;
      bias    = 8'hA5;
      chk({tag, "_x_ready_after_start"}, int'(x_ready), 1);
      chk({tag, "_busy_in_accum"}, int'(busy), 1);
      for (int i = 0; i < N; i++) begin
         if (gaps) begin
            x_valid = 1'b0;
            x_data  = 8'h7F;
            w_data  = 8'h7F;
            tick();
         end
         x_valid = 1'b1;
         x_data  = xv[i];
         w_data  = wv[i];
         tick();
      end
      x_valid = 1'b0;
      x_data  = '0;
      w_data  = '0;
      chk({tag, "_z_valid_in_final"}, int'(z_valid), 0);
      chk({tag, "_x_ready_in_final"}, int'(x_ready), 0);
      tick();
      chk({tag, "_z_valid_latency"}, int'(z_valid), 1);
      result = int'(z_value);
      if (hold > 0) begin
         for (int h = 0; h < hold; h++) begin
            start = (h == 1);
            tick();
            chk({tag, "_z_valid_held"}, int'(z_valid), 1);
            chk({tag, "_z_value_stable"}, int'(z_value), result);
         end
         start   = 1'b0;
         z_ready = 1'b1;
         tick();
      end else begin
         tick();
      end
      chk({tag, "_busy_after_handoff"}, int'(busy), 0);
      chk({tag, "_z_valid_after_handoff"}, int'(z_valid), 0);
      z_ready = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      bias    = '0;
      x_valid = 1'b0;
      x_data  = '0;
      w_data  = '0;
      z_ready = 1'b0;
      tick();
      tick();
      chk("reset_x_ready", int'(x_ready), 0);
      chk("reset_z_valid", int'(z_valid), 0);
      chk("reset_z_value", int'(z_value), 0);
      chk("reset_busy", int'(busy), 0);
      rst = 1'b0;
      tick();

      set_vec(8'h10, 8'h08);
      run_eval(8'h10, 1'b0, 0, "basic", got);
      chk("basic_literal", got, 'h30);

      set_vec(8'h10, 8'h20);
      run_eval(8'h10, 1'b0, 0, "pos_sat", got);
      chk("pos_sat_literal", got, 'h7F);

      set_vec(8'h70, 8'h90);
      run_eval(8'h00, 1'b0, 0, "neg_sat", got);
      chk("neg_sat_literal", got, 'h80);

      set_vec(8'h01, 8'h02);
      run_eval(8'h00, 1'b0, 0, "round_pos", got);
`ifdef NEURON_MAC_ROUND_EN
      chk("round_pos_literal", got, 'h01);
`else
      chk("round_pos_literal", got, 'h00);
`endif

      set_vec(8'h01, 8'hFE);
      run_eval(8'h00, 1'b0, 0, "round_neg", got);
`ifdef NEURON_MAC_ROUND_EN
      chk("round_neg_literal", got, 'h00);
`else
      chk("round_neg_literal", got, 'hFF);
`endif

      set_vec(8'h10, 8'h08);
      run_eval(8'h10, 1'b1, 0, "gaps", got);
      chk("gaps_literal", got, 'h30);

      // Mixed signs: 512 - 256 + 512 - 1536 + 128 = -640 -> -40
      xv[0] = 8'h20; wv[0] = 8'h10;
      xv[1] = 8'hF0; wv[1] = 8'h10;
      xv[2] = 8'h08; wv[2] = 8'h40;
      xv[3] = 8'h30; wv[3] = 8'hE0;
      run_eval(8'h08, 1'b0, 5, "backpressure", got);
      chk("backpressure_literal", got, 'hD8);

      // Abort after two large beats, then a clean evaluation must be unaffected.
      set_vec(8'h70, 8'h70);
      z_ready = 1'b1;
      start   = 1'b1;
      bias    = 8'h40;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         x_valid = 1'b1;
         x_data  = xv[i];
         w_data  = wv[i];
         tick();
      end
      x_valid = 1'b0;
      rst     = 1'b1;
      tick();
      chk("abort_busy", int'(busy), 0);
      chk("abort_x_ready", int'(x_ready), 0);
      chk("abort_z_valid", int'(z_valid), 0);
      rst = 1'b0;
      tick();
      set_vec(8'h10, 8'h08);
      run_eval(8'h10, 1'b0, 0, "after_abort", got);
      chk("after_abort_literal", got, 'h30);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/neuron_mac_z.md
# neuron_mac_z

Sequential multiply-accumulate stage that computes one neuron's pre-activation value z = Σ(xᵢ·wᵢ) + b in Q4.4 fixed point. It accepts one input/weight pair per beat over a valid/ready stream. It then produces a saturated 8-bit signed `z_value` behind a valid/ready output handshake. It sits directly upstream of the activation-function block (LUT + interpolator), whose `z__value` input it drives.

## Interface
- `N_INPUTS`, default 4: number of x/w pairs per neuron evaluation; must be ≥ 1.
- `FRAC_W`, default 4: fractional bits of all 8-bit operands and of the result (Q4.4).
- `ACC_W`, default 20: accumulator width; must satisfy ACC_W ≥ 16 + clog2(N_INPUTS+1).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin an evaluation; sampled only in IDLE.
- `bias` in 8: signed Q4.4 bias b, latched on the accepted `start`.
- `x_valid` in 1: input beat valid.
- `x_ready` out 1: block accepts a beat this cycle.
- `x_data` in 8: signed Q4.4 input xᵢ.
- `w_data` in 8: signed Q4.4 weight wᵢ, paired with `x_data`.
- `z_valid` out 1: `z_value` holds a result.
- `z_ready` in 1: downstream consumes the result.
- `z_value` out 8: signed Q4.4 saturated pre-activation.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM with four states: IDLE, ACCUM, FINAL, OUT.
- IDLE: `start`=1 latches `bias`, clears the accumulator and the beat counter, and moves to ACCUM.
- ACCUM: `x_ready`=1. On each beat where `x_valid`&`x_ready`, the 16-bit signed product x·w (Q8.8) is sign-extended and added to the accumulator, and the counter increments. The beat that reaches N_INPUTS moves the FSM to FINAL.
- FINAL, 1 cycle: sum = acc + (sign-extended bias << FRAC_W). Result = sum >>> FRAC_W (arithmetic shift, truncation toward −∞). The result is saturated to [−128, 127] (0x80..0x7F) and registered into `z_value`. Then move to OUT.
- OUT: `z_valid`=1; `z_value` stays stable. Cycles with `z_valid`&`z_ready` return the FSM to IDLE.
- `start` outside IDLE is ignored. `x_valid` outside ACCUM is ignored (`x_ready`=0).
- `rst` in any state returns to IDLE and discards any partial sum.
- Reset values: `x_ready`=0, `z_valid`=0, `z_value`=0x00, `busy`=0; accumulator and counter = 0.
- The accumulator never overflows when the ACC_W rule holds; saturation is applied only at FINAL.

## Timing
- Accepted `start` at cycle t: `x_ready`=1 from t+1.
- Last beat accepted at cycle u: FINAL at u+1, `z_valid`=1 from u+2.
- Minimum evaluation is N_INPUTS+3 cycles from `start` to `z_valid` when `x_valid` is held high; back-to-back evaluations need one IDLE cycle between them.
- Gaps in `x_valid` stall accumulation without loss of state.
- `z_ready` held low keeps the FSM in OUT indefinitely with `z_value` unchanged.
- `z_ready` may be high before `z_valid`; handoff occurs in the first OUT cycle.

## Configuration
- `NEURON_MAC_ROUND_EN` defined: FINAL adds 1 << (FRAC_W−1) to the sum before the shift, giving round-half-up.
- `NEURON_MAC_ROUND_EN` not defined: plain truncation toward −∞.
- Latency and all other behaviour are identical with and without the macro.

## Structure
- Shared package `neuron_pkg`:
  - Q-format constants: DATA_W=8, FRAC_W=4, Q_MAX=8'sh7F, Q_MIN=8'sh80.
  - FSM state enum: IDLE, ACCUM, FINAL, OUT.
- One sub-module, `neuron_sat`: combinational shift, optional rounding and saturation from ACC_W bits to 8 bits. It is shared with other stages that narrow accumulators.

## Test plan
- Basic sum: N=4, every x=0x10, every w=0x08, bias=0x10 → z_value=0x30; `z_valid` asserted 2 cycles after the 4th beat.
- Positive saturation: x=0x10, w=0x20 ×4, bias=0x10 → 9.0 → z_value=0x7F.
- Negative saturation: x=0x70, w=0x90 ×4, bias=0x00 → −196 → z_value=0x80.
- Rounding, x=0x01, w=0x02 ×4, bias=0:
  - without macro → 0x00; with `NEURON_MAC_ROUND_EN` → 0x01.
  - same with w=0xFE: without macro → 0xFF; with macro → 0x00.
- Backpressure and gaps:
  - `x_valid` toggles 1/0 during ACCUM → same result as the basic-sum case.
  - `z_ready` held low 5 cycles → `z_value` stable and `start` ignored; FSM returns to IDLE the cycle after `z_ready` rises.
- Reset mid-operation: `rst` after 2 beats → next cycle `busy`=0, `x_ready`=0, `z_valid`=0. A fresh evaluation then gives the correct result with no residue from the aborted sum.
